// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle MIPS datapath
module multicycle_control #(
    parameter int CNT_W        = 16,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic             done_s, pc_write_s, branch_s;
    logic             ir_write_s, mem_write_s, reg_write_s;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    assign done_s  = (state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                     (state_q == S_BRANCH) || (state_q == S_ADDIWB) || (state_q == S_JUMP);
    assign count_d = done_s ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        iord        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s  = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                pc_write_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch_s    = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates the write strobes so nothing in the datapath changes while held.
    assign pc_en       = reset & (pc_write_s | (branch_s & zero));
    assign ir_write    = reset & ir_write_s;
    assign mem_write   = reset & mem_write_s;
    assign reg_write   = reset & reg_write_s;
    assign state       = state_q;
    assign instr_done  = done_s;
    assign instr_count = count_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;

    logic       pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       instr_done, illegal_op;
    logic [15:0] instr_count;

    logic       h_pc_en, h_iord, h_mem_write, h_ir_write, h_mem_to_reg, h_reg_dst, h_reg_write, h_alu_src_a;
    logic [1:0] h_alu_src_b, h_pc_src;
    logic [2:0] h_alu_control;
    logic [3:0] h_state;
    logic       h_instr_done, h_illegal_op;
    logic [15:0] h_instr_count;

    logic       c_pc_en, c_iord, c_mem_write, c_ir_write, c_mem_to_reg, c_reg_dst, c_reg_write, c_alu_src_a;
    logic [1:0] c_alu_src_b, c_pc_src;
    logic [2:0] c_alu_control;
    logic [3:0] c_state;
    logic       c_instr_done, c_illegal_op;
    logic [3:0] c_instr_count;

    int tests_run = 0;
    int tests_failed = 0;
    int done_pulses;

    always #5 clk = ~clk;

    multicycle_control u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .state(state), .instr_done(instr_done),
        .instr_count(instr_count), .illegal_op(illegal_op)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b1)) u_halt (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(h_pc_en), .iord(h_iord), .mem_write(h_mem_write), .ir_write(h_ir_write),
        .mem_to_reg(h_mem_to_reg), .reg_dst(h_reg_dst), .reg_write(h_reg_write),
        .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .alu_control(h_alu_control),
        .pc_src(h_pc_src), .state(h_state), .instr_done(h_instr_done),
        .instr_count(h_instr_count), .illegal_op(h_illegal_op)
    );

    multicycle_control #(.CNT_W(4)) u_cnt4 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(c_pc_en), .iord(c_iord), .mem_write(c_mem_write), .ir_write(c_ir_write),
        .mem_to_reg(c_mem_to_reg), .reg_dst(c_reg_dst), .reg_write(c_reg_write),
        .alu_src_a(c_alu_src_a), .alu_src_b(c_alu_src_b), .alu_control(c_alu_control),
        .pc_src(c_pc_src), .state(c_state), .instr_done(c_instr_done),
        .instr_count(c_instr_count), .illegal_op(c_illegal_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (instr_done) done_pulses++;
    endtask

    initial begin
        reset = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0; done_pulses = 0;
        #12;
        check_eq("rst_state", state, 0);
        check_eq("rst_pc_en", pc_en, 0);
        check_eq("rst_ir_write", ir_write, 0);
        check_eq("rst_count", instr_count, 0);
        check_eq("rst_illegal", illegal_op, 0);
        check_eq("rst_alu_src_b", alu_src_b, 1);
        reset = 1'b1;
        #1;
        check_eq("fetch_ir_write", ir_write, 1);
        check_eq("fetch_pc_en", pc_en, 1);

        // lw: 0,1,2,3,4,0
        tick(); check_eq("lw_s1", state, 1);
        tick(); check_eq("lw_s2", state, 2);
        tick(); check_eq("lw_s3", state, 3);
        check_eq("lw_memrd_iord", iord, 1);
        check_eq("lw_memrd_regwr", reg_write, 0);
        tick(); check_eq("lw_s4", state, 4);
        check_eq("lw_memwb_regwr", reg_write, 1);
        check_eq("lw_memwb_m2r", mem_to_reg, 1);
        check_eq("lw_memwb_done", instr_done, 1);
        tick(); check_eq("lw_s0", state, 0);
        check_eq("lw_count", instr_count, 1);

        // R-type sub
        op = 6'b000000; funct = 6'b100010; done_pulses = 0;
        tick(); check_eq("r_s1", state, 1);
        tick(); check_eq("r_s6", state, 6);
        check_eq("r_exec_aluc", alu_control, 3'b110);
        check_eq("r_exec_srca", alu_src_a, 1);
        tick(); check_eq("r_s7", state, 7);
        check_eq("r_aluwb_regdst", reg_dst, 1);
        check_eq("r_aluwb_regwr", reg_write, 1);
        tick(); check_eq("r_s0", state, 0);
        check_eq("r_done_pulses", done_pulses, 1);
        check_eq("r_count", instr_count, 2);

        // beq taken then not taken
        op = 6'b000100; zero = 1'b1;
        tick(); tick(); check_eq("beq1_s8", state, 8);
        check_eq("beq1_pc_en", pc_en, 1);
        check_eq("beq1_pc_src", pc_src, 1);
        check_eq("beq1_aluc", alu_control, 3'b110);
        tick(); check_eq("beq1_s0", state, 0);
        zero = 1'b0;
        tick(); tick(); check_eq("beq0_s8", state, 8);
        check_eq("beq0_pc_en", pc_en, 0);
        tick(); check_eq("beq0_s0", state, 0);
        check_eq("beq_count", instr_count, 4);

        // sw then j
        op = 6'b101011;
        tick(); tick(); check_eq("sw_s2", state, 2);
        check_eq("sw_memadr_srcb", alu_src_b, 2);
        tick(); check_eq("sw_s5", state, 5);
        check_eq("sw_mem_write", mem_write, 1);
        check_eq("sw_iord", iord, 1);
        tick(); check_eq("sw_s0", state, 0);
        op = 6'b000010;
        tick(); check_eq("j_decode_srcb", alu_src_b, 3);
        tick(); check_eq("j_s11", state, 11);
        check_eq("j_pc_src", pc_src, 2);
        check_eq("j_pc_en", pc_en, 1);
        tick(); check_eq("j_s0", state, 0);
        check_eq("sw_j_count", instr_count, 6);

        // addi
        op = 6'b001000;
        tick(); tick(); check_eq("addi_s9", state, 9);
        tick(); check_eq("addi_s10", state, 10);
        check_eq("addi_regdst", reg_dst, 0);
        check_eq("addi_regwr", reg_write, 1);
        tick(); check_eq("addi_count", instr_count, 7);

        // illegal op
        op = 6'b111111;
        tick(); tick(); check_eq("ill_s0", state, 0);
        check_eq("ill_flag", illegal_op, 1);
        check_eq("ill_count", instr_count, 7);
        check_eq("ill_halt_state", h_state, 15);
        op = 6'b100011;
        repeat (5) tick();
        check_eq("ill_sticky", illegal_op, 1);
        check_eq("ill_after_lw_count", instr_count, 8);
        check_eq("halt_holds", h_state, 15);
        check_eq("halt_count", h_instr_count, 7);

        // reset during MEMRD
        tick(); tick(); tick(); check_eq("mid_s3", state, 3);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_state", state, 0);
        check_eq("mid_rst_regwr", reg_write, 0);
        check_eq("mid_rst_memwr", mem_write, 0);
        check_eq("mid_rst_pc_en", pc_en, 0);
        check_eq("mid_rst_count", instr_count, 0);
        check_eq("mid_rst_illegal", illegal_op, 0);
        check_eq("mid_rst_halt", h_state, 0);
        @(negedge clk);
        reset = 1'b1;

        // counter wrap with CNT_W=4
        op = 6'b000100; zero = 1'b0;
        repeat (15) begin tick(); tick(); tick(); end
        check_eq("wrap_15", c_instr_count, 15);
        tick(); tick(); tick();
        check_eq("wrap_0", c_instr_count, 0);
        check_eq("wide_16", instr_count, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main controller for the multicycle MIPS datapath. Decodes the instruction register opcode and funct fields and sequences the datapath through fetch, decode, execute, memory and writeback steps. Drives every enable and mux select in the datapath for one instruction at a time. Also keeps a retired-instruction count and flags illegal opcodes for the top-level bench.

Parameters:
CNT_W, 16, width of the retired-instruction counter
ILLEGAL_HALT, 0, when 1 an illegal opcode parks the FSM in HALT instead of returning to FETCH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  6  instruction register bits [31:26]
funct  input  6  instruction register bits [5:0]
zero  input  1  ALU zero flag from datapath
pc_en  output  1  PC load enable = pc_write | (branch & zero)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  register write data select: 1 = MDR, 0 = ALUOut
reg_dst  output  1  destination select: 1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current FSM state, for debug
instr_done  output  1  one-cycle pulse in the last cycle of each instruction
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
illegal_op  output  1  sticky; set when DECODE sees an unsupported opcode

Behaviour:
- Moore FSM. All outputs are decoded from state only, except pc_en, which also uses the zero input.
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 EXEC, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP, 15 HALT
- Transitions:
  - FETCH -> DECODE
  - DECODE -> by op:
    - 100011 lw and 101011 sw -> MEMADR
    - 000000 R-type -> EXEC
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - any other op -> FETCH, or HALT when ILLEGAL_HALT = 1
  - MEMADR -> MEMRD for lw, MEMWR for sw
  - MEMRD -> MEMWB; EXEC -> ALUWB; ADDIEX -> ADDIWB
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH
  - HALT holds until reset.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Control outputs per state (any output not listed is 0):
  - FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, pc_write=1
  - DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target precomputed)
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010
  - MEMRD: iord=1
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1
  - MEMWR: iord=1, mem_write=1
  - EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct
    - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
    - any other funct -> 010
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, branch=1
  - JUMP: pc_src=10, pc_write=1
- instr_done is 1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP. instr_count increments on the same clock edge that leaves those states.
- Reset (reset=0, asynchronous):
  - state=FETCH, instr_count=0, illegal_op=0.
  - While reset is low, pc_en, ir_write, mem_write and reg_write are forced to 0; the other outputs show their FETCH values.
  - Reset mid-instruction abandons the instruction without incrementing the counter.
- After reset deasserts, the first rising edge executes FETCH.
- illegal_op is set on the clock edge leaving DECODE with an unsupported op and clears only on reset. The illegal instruction is not counted.
- The op and funct inputs are required stable from DECODE through the last cycle of the instruction; the IR changes only in FETCH.

Test Plan:
- Reset low, then high, op=100011 held -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1 after 5 cycles.
- op=000000, funct=100010 -> EXEC shows alu_control=110; ALUWB shows reg_dst=1 and reg_write=1; 4 cycles; instr_done pulses once.
- op=000100 with zero=1, then with zero=0 -> in BRANCH, pc_en=1 and pc_src=01 for the first case; pc_en=0 for the second; both take 3 cycles.
- op=101011 then op=000010 -> MEMWR shows mem_write=1 and iord=1; JUMP shows pc_src=10 and pc_en=1; instr_count=2 after 7 cycles.
- op=111111 with ILLEGAL_HALT=0 -> DECODE returns to FETCH; illegal_op=1 stays set; instr_count unchanged. With ILLEGAL_HALT=1 -> state=15 until reset.
- Reset low during MEMRD -> state=0 immediately, all write enables 0, instr_count=0. Separately, CNT_W=4 with 16 beq instructions -> count wraps to 0.
